// File: rtl/conv_result_checker.sv
// conv_result_checker: consumes the convolution core's output stream.
// It accumulates each packet of samples, forms the packet average by a
// right shift, and checks packet length. In Test mode it compares each
// average against a golden value and keeps a sticky pass flag.
module conv_result_checker #(
    parameter int                 DATA_W     = 16,
    parameter int                 LOG2_PKT   = 4,
    parameter int                 PKT_LEN    = 16,
    parameter logic [DATA_W-1:0]  GOLDEN_AVG = 16'd100
) (
    input  logic                         clk,
    input  logic                         Reset_in,
    input  logic [DATA_W-1:0]            Y,
    input  logic                         valid,
    input  logic                         packet_Done,
    input  logic                         Test,
    output logic                         ready,
    output logic [DATA_W+LOG2_PKT-1:0]   sum,
    output logic [8:0]                   count,
    output logic [3:0]                   count1,
    output logic [DATA_W-1:0]            avrg,
    output logic                         avg_valid,
    output logic                         len_error,
    output logic                         Test_Result
);

    localparam int SUM_W = DATA_W + LOG2_PKT;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic                accept_s;
    logic                ready_r;
    logic                avg_valid_r;
    logic [SUM_W-1:0]    sum_r;
    logic [8:0]          count_r;
    logic [3:0]          count1_r;
    logic [DATA_W-1:0]   avrg_r;
    logic                len_error_r;
    logic                test_result_r;
    // Remembers whether any packet has been judged in Test mode yet, so the
    // first judgement overwrites the pass flag and later ones AND into it.
    logic                tested_r;
    logic [DATA_W-1:0]   avrg_new_s;
    logic                len_error_new_s;
    logic                pass_s;

    assign accept_s = valid & ready_r;

    // Next-state decode for the packet FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (packet_Done) begin
                        next_state_s = DIVIDE;
                    end else begin
                        next_state_s = ACCUM;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s && packet_Done) begin
                    next_state_s = DIVIDE;
                end else begin
                    next_state_s = ACCUM;
                end
            end
            DIVIDE:  next_state_s = REPORT;
            REPORT:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Packet verdict terms evaluated while in DIVIDE.
    always_comb begin
        avrg_new_s      = sum_r[SUM_W-1:LOG2_PKT];
        len_error_new_s = len_error_r | (count_r != 9'(PKT_LEN));
        pass_s          = (avrg_new_s == GOLDEN_AVG) & ~len_error_new_s;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge Reset_in) begin
        if (Reset_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath and registered handshake/report outputs.
    always_ff @(posedge clk or posedge Reset_in) begin
        if (Reset_in) begin
            ready_r       <= 1'b1;
            avg_valid_r   <= 1'b0;
            sum_r         <= '0;
            count_r       <= 9'd0;
            count1_r      <= 4'd0;
            avrg_r        <= '0;
            len_error_r   <= 1'b0;
            test_result_r <= 1'b0;
            tested_r      <= 1'b0;
        end else begin
            ready_r     <= (next_state_s == IDLE) || (next_state_s == ACCUM);
            avg_valid_r <= (next_state_s == REPORT);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sum_r   <= SUM_W'(Y);
                        count_r <= 9'd1;
                    end
                end
                ACCUM: begin
                    if (accept_s) begin
                        // Wraps modulo 2**SUM_W on over-long packets.
                        sum_r <= sum_r + SUM_W'(Y);
                        if (count_r == 9'd511) begin
                            len_error_r <= 1'b1;
                        end else begin
                            count_r <= count_r + 9'd1;
                        end
                    end
                end
                DIVIDE: begin
                    avrg_r      <= avrg_new_s;
                    count1_r    <= count1_r + 4'd1;
                    len_error_r <= len_error_new_s;
                    if (Test) begin
                        tested_r      <= 1'b1;
                        test_result_r <= tested_r ? (test_result_r & pass_s) : pass_s;
                    end
                end
                REPORT: begin
                    sum_r <= sum_r;
                end
                default: begin
                    sum_r <= sum_r;
                end
            endcase
        end
    end

    assign ready       = ready_r;
    assign avg_valid   = avg_valid_r;
    assign sum         = sum_r;
    assign count       = count_r;
    assign count1      = count1_r;
    assign avrg        = avrg_r;
    assign len_error   = len_error_r;
    assign Test_Result = test_result_r;

endmodule
